// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
//   state_t : loader FSM states
//   err_t   : sticky error code reported on err_code
//   HDR_BYTES : bytes per header field / data word in the input stream
package loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      CLEAR,
      HDR_BASE,
      HDR_CNT,
      DATA,
      WRITE,
      RUN,
      HALT,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_ALIGN   = 2'd1,
      ERR_SIZE    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_t;

   localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian 32-bit words (first byte -> bits [7:0]).
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-high reset
//   clear_i      restart at byte lane 0
//   byte_en_i    a byte is accepted this cycle
//   byte_i       the accepted byte
//   word_o       assembled word; valid in the cycle word_done_o is high
//   word_done_o  high on the 4th accepted byte of a word
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);

   localparam logic [1:0] LastLane = 2'(HDR_BYTES - 1);

   logic [1:0]  lane_q, lane_d;
   // Only the first three bytes need storage; the 4th comes straight from byte_i.
   logic [23:0] shift_q, shift_d;

   always_comb begin
      lane_d  = lane_q;
      shift_d = shift_q;
      if (clear_i) begin
         lane_d = '0;
      end else if (byte_en_i) begin
         lane_d  = lane_q + 2'd1;
         shift_d = {byte_i, shift_q[23:8]};
      end
   end

   assign word_o      = {byte_i, shift_q};
   assign word_done_o = byte_en_i && !clear_i && (lane_q == LastLane);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lane_q  <= '0;
         shift_q <= '0;
      end else begin
         lane_q  <= lane_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Initiator side of the miniRV memory-load port. Receives BASE, COUNT and COUNT data
// words as a little-endian byte stream, writes the words to core memory at BASE+4*k,
// releases the core from reset and counts run cycles until ebreak or timeout.
// Ports:
//   clk, reset                 clock / asynchronous active-high reset
//   start                      begin a session (only from IDLE, HALT or ERR)
//   in_valid, in_byte, in_ready  byte stream handshake
//   ebreak                     core reached ebreak
//   rom_wen, rom_addr, rom_wdata  core memory write port
//   core_reg_reset, core_mem_reset  core reset controls
//   busy, halted, err_code, run_cycles  status
module prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 1024,
   parameter int unsigned TIMEOUT   = 1048576,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [7:0]       in_byte,
   output logic             in_ready,
   input  logic             ebreak,
   output logic             rom_wen,
   output logic [31:0]      rom_addr,
   output logic [31:0]      rom_wdata,
   output logic             core_reg_reset,
   output logic             core_mem_reset,
   output logic             busy,
   output logic             halted,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] run_cycles
);

   state_t           state_q, state_d;
   logic [31:0]      base_q, base_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] k_q, k_d;
   logic [CNT_W-1:0] k_next;
   logic [CNT_W-1:0] run_q, run_d;
   err_t             err_q, err_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;

   logic             rom_wen_q, rom_wen_d;
   logic             reg_rst_q, reg_rst_d;
   logic             mem_rst_q, mem_rst_d;
   logic             busy_q, busy_d;
   logic             halted_q, halted_d;

   logic             byte_en;
   logic             pk_clear;
   logic [31:0]      pk_word;
   logic             pk_done;

   assign in_ready = (state_q == HDR_BASE) || (state_q == HDR_CNT) || (state_q == DATA);
   assign byte_en  = in_valid && in_ready;
   assign k_next   = k_q + CNT_W'(1);

   byte_packer u_packer (
      .clk_i       (clk),
      .rst_i       (reset),
      .clear_i     (pk_clear),
      .byte_en_i   (byte_en),
      .byte_i      (in_byte),
      .word_o      (pk_word),
      .word_done_o (pk_done)
   );

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      count_d  = count_q;
      k_d      = k_q;
      run_d    = run_q;
      err_d    = err_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      pk_clear = 1'b0;

      unique case (state_q)
         IDLE, HALT, ERR: begin
            // Clear status on the way into CLEAR so it already reads as cleared there.
            if (start) begin
               state_d = CLEAR;
               k_d     = '0;
               run_d   = '0;
               err_d   = ERR_NONE;
            end
         end
         CLEAR: begin
            pk_clear = 1'b1;
            state_d  = HDR_BASE;
         end
         HDR_BASE: begin
            if (pk_done) begin
               base_d = pk_word;
               if (pk_word[1:0] != 2'b00) begin
                  err_d   = ERR_ALIGN;
                  state_d = ERR;
               end else begin
                  state_d = HDR_CNT;
               end
            end
         end
         HDR_CNT: begin
            if (pk_done) begin
               count_d = CNT_W'(pk_word);
               if (pk_word > 32'(MAX_WORDS)) begin
                  err_d   = ERR_SIZE;
                  state_d = ERR;
               end else if (pk_word == 32'd0) begin
                  state_d = RUN;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (pk_done) begin
               // Address wraps mod 2^32 by construction.
               addr_d  = base_q + (32'(k_q) << 2);
               wdata_d = pk_word;
               state_d = WRITE;
            end
         end
         WRITE: begin
            k_d     = k_next;
            state_d = (k_next == count_q) ? RUN : DATA;
         end
         RUN: begin
            // ebreak takes priority over the timeout and is not counted.
            if (ebreak) begin
               state_d = HALT;
            end else if (run_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = ERR_TIMEOUT;
               state_d = ERR;
            end else begin
               run_d = run_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs are decoded from the next state so they line up with state_q.
   always_comb begin
      rom_wen_d = (state_d == WRITE);
      reg_rst_d = !((state_d == RUN) || (state_d == HALT));
      mem_rst_d = (state_d == CLEAR);
      busy_d    = (state_d == CLEAR) || (state_d == HDR_BASE) || (state_d == HDR_CNT) ||
                  (state_d == DATA) || (state_d == WRITE) || (state_d == RUN);
      halted_d  = (state_d == HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         base_q    <= '0;
         count_q   <= '0;
         k_q       <= '0;
         run_q     <= '0;
         err_q     <= ERR_NONE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rom_wen_q <= 1'b0;
         reg_rst_q <= 1'b1;
         mem_rst_q <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         count_q   <= count_d;
         k_q       <= k_d;
         run_q     <= run_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rom_wen_q <= rom_wen_d;
         reg_rst_q <= reg_rst_d;
         mem_rst_q <= mem_rst_d;
         busy_q    <= busy_d;
         halted_q  <= halted_d;
      end
   end

   assign rom_wen        = rom_wen_q;
   assign rom_addr       = addr_q;
   assign rom_wdata      = wdata_q;
   assign core_reg_reset = reg_rst_q;
   assign core_mem_reset = mem_rst_q;
   assign busy           = busy_q;
   assign halted         = halted_q;
   assign err_code       = err_q;
   assign run_cycles     = run_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader. A queue-based model lists the memory
// writes an image must produce (BASE+4*i, word i) and the final status is derived from
// the session rules (alignment, size, ebreak delay vs timeout).
module tb_prog_loader;
   import loader_pkg::*;

   localparam int unsigned MaxWords = 8;
   localparam int unsigned Timeout  = 16;
   localparam int unsigned CntW     = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            in_valid;
   logic [7:0]      in_byte;
   logic            in_ready;
   logic            ebreak;
   logic            rom_wen;
   logic [31:0]     rom_addr;
   logic [31:0]     rom_wdata;
   logic            core_reg_reset;
   logic            core_mem_reset;
   logic            busy;
   logic            halted;
   logic [1:0]      err_code;
   logic [CntW-1:0] run_cycles;

   int          n_checks = 0;
   int          n_errors = 0;
   bit          tog      = 1'b0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] img[$];

   always #5 clk = ~clk;

   prog_loader #(
      .MAX_WORDS (MaxWords),
      .TIMEOUT   (Timeout),
      .CNT_W     (CntW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .in_valid       (in_valid),
      .in_byte        (in_byte),
      .in_ready       (in_ready),
      .ebreak         (ebreak),
      .rom_wen        (rom_wen),
      .rom_addr       (rom_addr),
      .rom_wdata      (rom_wdata),
      .core_reg_reset (core_reg_reset),
      .core_mem_reset (core_mem_reset),
      .busy           (busy),
      .halted         (halted),
      .err_code       (err_code),
      .run_cycles     (run_cycles)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Every write strobe must match the next entry of the model's write list.
   always @(negedge clk) begin
      if (!reset && rom_wen === 1'b1) begin
         check_eq("wen_expected", 32'(exp_addr_q.size() > 0), 1);
         if (exp_addr_q.size() > 0) begin
            check_eq("wr_addr", rom_addr, exp_addr_q.pop_front());
            check_eq("wr_data", rom_wdata, exp_data_q.pop_front());
            check_eq("wr_core_held", 32'(core_reg_reset), 1);
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_wen"}, 32'(rom_wen), 0);
      check_eq({tag, "_addr"}, rom_addr, 0);
      check_eq({tag, "_wdata"}, rom_wdata, 0);
      check_eq({tag, "_ready"}, 32'(in_ready), 0);
      check_eq({tag, "_regrst"}, 32'(core_reg_reset), 1);
      check_eq({tag, "_memrst"}, 32'(core_mem_reset), 0);
      check_eq({tag, "_busy"}, 32'(busy), 0);
      check_eq({tag, "_halted"}, 32'(halted), 0);
      check_eq({tag, "_err"}, 32'(err_code), 0);
      check_eq({tag, "_runcyc"}, run_cycles, 0);
   endtask

   // mode: 0 = in_valid held, 1 = toggled every other cycle, 2 = random stalls
   task automatic send_byte(input logic [7:0] b, input int mode);
      bit done  = 1'b0;
      int guard = 0;
      while (!done) begin
         @(negedge clk);
         if ((mode == 1 && tog) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_byte  = b;
            done     = in_ready;
         end
         tog = ~tog;
         guard++;
         if (!done && guard > 200) begin
            check_eq("byte_accept", 32'(in_ready), 1);
            done = 1'b1;
         end
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int mode);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], mode);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // d >= 0: ebreak after d counted run cycles; d < 0: never raise ebreak.
   task automatic session(input logic [31:0] base, input int unsigned n, input int mode,
                          input int d, input bit busy_start);
      logic [31:0] w;
      bit          ok;
      int          cyc;
      pulse_start();
      check_eq("clear_memrst", 32'(core_mem_reset), 1);
      check_eq("clear_busy", 32'(busy), 1);
      check_eq("clear_err", 32'(err_code), 0);
      check_eq("clear_runcyc", run_cycles, 0);
      check_eq("clear_halted", 32'(halted), 0);
      check_eq("clear_regrst", 32'(core_reg_reset), 1);
      send_word(base, mode);
      if (base[1:0] != 2'b00) begin
         @(negedge clk);
         in_valid = 1'b0;
         check_eq("align_err", 32'(err_code), ERR_ALIGN);
         check_eq("align_regrst", 32'(core_reg_reset), 1);
         check_eq("align_busy", 32'(busy), 0);
         check_eq("align_ready", 32'(in_ready), 0);
         return;
      end
      send_word(n, mode);
      if (n > MaxWords) begin
         @(negedge clk);
         in_valid = 1'b0;
         check_eq("size_err", 32'(err_code), ERR_SIZE);
         check_eq("size_regrst", 32'(core_reg_reset), 1);
         check_eq("size_busy", 32'(busy), 0);
         return;
      end
      if (busy_start && n > 0) pulse_start();
      for (int unsigned i = 0; i < n; i++) begin
         w = (img.size() > 0) ? img.pop_front() : $urandom;
         exp_addr_q.push_back(base + 32'(4 * i));
         exp_data_q.push_back(w);
         send_word(w, mode);
      end
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (core_reg_reset == 1'b0) ok = 1'b1;
      end
      check_eq("reach_run", 32'(ok), 1);
      if (!ok) return;
      check_eq("writes_done", exp_addr_q.size(), 0);
      check_eq("run_busy", 32'(busy), 1);
      if (d >= 0) begin
         repeat (d) @(negedge clk);
         ebreak = 1'b1;
         @(negedge clk);
         ebreak = 1'b0;
         check_eq("halt_halted", 32'(halted), 1);
         check_eq("halt_err", 32'(err_code), ERR_NONE);
         check_eq("halt_runcyc", run_cycles, d);
         check_eq("halt_regrst", 32'(core_reg_reset), 0);
         check_eq("halt_busy", 32'(busy), 0);
         repeat (3) @(negedge clk);
         check_eq("halt_frozen", run_cycles, d);
      end else begin
         cyc = 1;
         while (core_reg_reset == 1'b0 && cyc < 100) begin
            @(negedge clk);
            if (core_reg_reset == 1'b0) cyc++;
         end
         check_eq("tmo_run_len", cyc, Timeout);
         check_eq("tmo_err", 32'(err_code), ERR_TIMEOUT);
         check_eq("tmo_runcyc", run_cycles, Timeout - 1);
         check_eq("tmo_halted", 32'(halted), 0);
         check_eq("tmo_busy", 32'(busy), 0);
      end
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] base;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      ebreak   = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("por");
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("idle");

      // Reference image, then the same with a toggling in_valid.
      img.push_back(32'h0010_0093);
      img.push_back(32'h0010_0073);
      session(32'h0, 2, 0, 1, 1'b0);
      img.push_back(32'h0010_0093);
      img.push_back(32'h0010_0073);
      session(32'h0, 2, 1, 1, 1'b0);

      session(32'h0000_0002, 2, 0, 1, 1'b0);
      session(32'h0, MaxWords + 1, 0, 1, 1'b0);
      session(32'h40, 0, 0, 3, 1'b0);
      session(32'h80, MaxWords, 2, 5, 1'b0);
      session(32'h10, 1, 0, -1, 1'b0);
      session(32'h200, 2, 0, 4, 1'b1);
      session(32'hFFFF_FFF8, 4, 2, Timeout - 1, 1'b0);

      // Reset asserted while a write is on the port.
      pulse_start();
      send_word(32'h0, 0);
      send_word(32'd3, 0);
      w = $urandom;
      exp_addr_q.push_back(32'h0);
      exp_data_q.push_back(w);
      send_word(w, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("pre_rst_wen", 32'(rom_wen), 1);
      #1 reset = 1'b1;
      #1 check_reset_vals("rst_write");
      exp_addr_q.delete();
      exp_data_q.delete();
      @(negedge clk);
      reset = 1'b0;
      session(32'h100, 3, 0, 2, 1'b0);

      for (int s = 0; s < 12; s++) begin
         base = $urandom;
         if ($urandom_range(0, 4) != 0) base[1:0] = 2'b00;
         session(base, $urandom_range(0, MaxWords + 1), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, Timeout)) - 1, 1'(($urandom_range(0, 3) == 0)));
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
